// File: rtl/pipe_reg_chain_pkg.sv
// Shared sizing helpers and constants for the elastic pipeline register chain
// and its optional output skid buffer.
package pipe_reg_chain_pkg;

   localparam int SKID_DEPTH = 2;

   function automatic int idxWidth(input int depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

   // Enough bits to count every stage plus both skid entries.
   function automatic int occWidth(input int depth);
      return $clog2(depth + SKID_DEPTH + 1);
   endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry output FIFO whose upstream ready depends only on its registered
// fill count, so downstream ready never reaches the chain combinationally.
module pipe_skid_buf
   import pipe_reg_chain_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             i_valid,
   output logic                             o_ready,
   input  logic [WIDTH-1:0]                 i_data,
   output logic                             o_valid,
   input  logic                             i_ready,
   output logic [WIDTH-1:0]                 o_data,
   output logic [idxWidth(SKID_DEPTH):0]    o_count
);

   localparam int PTR_W = idxWidth(SKID_DEPTH);

   logic [WIDTH-1:0] r_mem [SKID_DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [PTR_W:0]   r_count;
   logic             w_push;
   logic             w_pop;

   assign o_ready = (r_count < (PTR_W+1)'(SKID_DEPTH));
   assign o_valid = (r_count != '0);
   assign o_data  = r_mem[r_rdPtr];
   assign o_count = r_count;
   assign w_push  = i_valid && o_ready;
   assign w_pop   = o_valid && i_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push)
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         if (w_pop)
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage carries no reset; only the count decides what is live.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wrPtr] <= i_data;
   end

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH elastic pipeline registers with valid/ready handshake, bubble
// collapsing, per-stage flush and an optional registered-ready output skid.
module pipe_reg_chain
   import pipe_reg_chain_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int SKID  = 0,
   parameter int CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data,
   input  logic                         flush,
   input  logic [DEPTH-1:0]             flush_mask,
   output logic [occWidth(DEPTH)-1:0]   occupancy,
   output logic [CNT_W-1:0]             stall_cnt
);

   localparam int OCC_W  = occWidth(DEPTH);
   localparam int SCNT_W = idxWidth(SKID_DEPTH) + 1;

   logic [DEPTH-1:0]  r_valid;
   logic [WIDTH-1:0]  r_data [DEPTH];
   logic [CNT_W-1:0]  r_stallCnt;

   logic [DEPTH:0]    w_ready;
   logic [DEPTH-1:0]  w_kill;
   logic [DEPTH-1:0]  w_loadValid;
   logic [WIDTH-1:0]  w_loadData [DEPTH];
   logic              w_tailReady;
   logic [SCNT_W-1:0] w_skidCount;
   logic [OCC_W-1:0]  w_occ;

   assign w_kill   = flush ? flush_mask : '0;
   assign in_ready = w_ready[0];

   // A stage can take a new entry when it is empty or its own entry moves on.
   always_comb begin
      w_ready        = '0;
      w_ready[DEPTH] = w_tailReady;
      for (int i = DEPTH - 1; i >= 0; i--)
         w_ready[i] = !r_valid[i] || w_ready[i+1];
   end

   // What each stage would capture: a killed predecessor arrives as a bubble.
   always_comb begin
      w_loadValid    = '0;
      w_loadValid[0] = in_valid && !w_kill[0];
      w_loadData[0]  = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         w_loadValid[i] = r_valid[i-1] && !w_kill[i-1];
         w_loadData[i]  = r_data[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_ready[i])
               r_valid[i] <= w_loadValid[i];
            else
               r_valid[i] <= r_valid[i] && !w_kill[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (w_ready[i] && w_loadValid[i])
            r_data[i] <= w_loadData[i];
      end
   end

   generate
      if (SKID != 0) begin : g_skid
         logic w_pushValid;

         // A flushed oldest stage never enters the skid buffer.
         assign w_pushValid = r_valid[DEPTH-1] && !w_kill[DEPTH-1];

         pipe_skid_buf #(
            .WIDTH (WIDTH)
         ) u_skid (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_valid (w_pushValid),
            .o_ready (w_tailReady),
            .i_data  (r_data[DEPTH-1]),
            .o_valid (out_valid),
            .i_ready (out_ready),
            .o_data  (out_data),
            .o_count (w_skidCount)
         );
      end else begin : g_direct
         // The output handshake wins over a flush of the oldest stage.
         assign w_tailReady = out_ready;
         assign out_valid   = r_valid[DEPTH-1];
         assign out_data    = r_data[DEPTH-1];
         assign w_skidCount = '0;
      end
   endgenerate

   always_comb begin
      w_occ = OCC_W'(w_skidCount);
      for (int i = 0; i < DEPTH; i++)
         w_occ = w_occ + OCC_W'(r_valid[i]);
   end

   assign occupancy = w_occ;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_stallCnt <= '0;
      else if (out_valid && !out_ready && (r_stallCnt != '1))
         r_stallCnt <= r_stallCnt + CNT_W'(1);
   end

   assign stall_cnt = r_stallCnt;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain: a direct (SKID=0) instance and a
// skid-buffered instance with a narrow saturating stall counter.
module tb_pipe_reg_chain;

   logic        clk;
   logic        rst_n;

   logic        inValid;
   logic        inReady;
   logic [31:0] inData;
   logic        outValid;
   logic        outReady;
   logic [31:0] outData;
   logic        flush;
   logic [3:0]  flushMask;
   logic [2:0]  occupancy;
   logic [15:0] stallCnt;

   logic        sInValid;
   logic        sInReady;
   logic [31:0] sInData;
   logic        sOutValid;
   logic        sOutReady;
   logic [31:0] sOutData;
   logic        sFlush;
   logic [3:0]  sFlushMask;
   logic [2:0]  sOcc;
   logic [2:0]  sStall;

   int checks;
   int errors;
   int nextSend;
   int expNext;
   int delivered;

   pipe_reg_chain #(
      .WIDTH (32),
      .DEPTH (4),
      .SKID  (0),
      .CNT_W (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (inValid),
      .in_ready   (inReady),
      .in_data    (inData),
      .out_valid  (outValid),
      .out_ready  (outReady),
      .out_data   (outData),
      .flush      (flush),
      .flush_mask (flushMask),
      .occupancy  (occupancy),
      .stall_cnt  (stallCnt)
   );

   pipe_reg_chain #(
      .WIDTH (32),
      .DEPTH (4),
      .SKID  (1),
      .CNT_W (3)
   ) dutSkid (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (sInValid),
      .in_ready   (sInReady),
      .in_data    (sInData),
      .out_valid  (sOutValid),
      .out_ready  (sOutReady),
      .out_data   (sOutData),
      .flush      (sFlush),
      .flush_mask (sFlushMask),
      .occupancy  (sOcc),
      .stall_cnt  (sStall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r,
                                input logic f, input logic [3:0] m);
      inValid   = v;
      inData    = d;
      outReady  = r;
      flush     = f;
      flushMask = m;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rst_n      = 1'b0;
      inValid    = 1'b0;
      inData     = '0;
      outReady   = 1'b0;
      flush      = 1'b0;
      flushMask  = '0;
      sInValid   = 1'b0;
      sInData    = '0;
      sOutReady  = 1'b0;
      sFlush     = 1'b0;
      sFlushMask = '0;

      // Reset state
      #2;
      checkOutput("rst_out_valid", 32'(outValid), 32'd0);
      checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
      checkOutput("rst_stall_cnt", 32'(stallCnt), 32'd0);
      checkOutput("rst_in_ready", 32'(inReady), 32'd1);
      checkOutput("rst_skid_in_ready", 32'(sInReady), 32'd1);
      checkOutput("rst_skid_out_valid", 32'(sOutValid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Streaming 1..8 with out_ready held high
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(1'b1, 32'(k), 1'b1, 1'b0, 4'b0000);
         checkOutput("stream_in_ready", 32'(inReady), 32'd1);
         tick();
         checkOutput("stream_occupancy", 32'(occupancy), (k < 4) ? 32'(k) : 32'd4);
         checkOutput("stream_out_valid", 32'(outValid), (k >= 4) ? 32'd1 : 32'd0);
         if (k >= 4)
            checkOutput("stream_out_data", outData, 32'(k - 3));
      end
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 4'b0000);
      for (int j = 1; j <= 3; j++) begin
         tick();
         checkOutput("drain_out_data", outData, 32'(5 + j));
         checkOutput("drain_occupancy", 32'(occupancy), 32'(4 - j));
      end
      tick();
      checkOutput("drain_empty", 32'(outValid), 32'd0);
      checkOutput("stream_stall_cnt", 32'(stallCnt), 32'd0);

      // Backpressure: fill A..D, hold out_ready low for 5 cycles, then release
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 32'hA + 32'(k), 1'b0, 1'b0, 4'b0000);
         tick();
      end
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 4'b0000);
      checkOutput("bp_in_ready_full", 32'(inReady), 32'd0);
      checkOutput("bp_occupancy_full", 32'(occupancy), 32'd4);
      checkOutput("bp_out_data_first", outData, 32'hA);
      checkOutput("bp_stall_before", 32'(stallCnt), 32'd0);
      repeat (5) tick();
      checkOutput("bp_stall_after5", 32'(stallCnt), 32'd5);
      checkOutput("bp_out_data_held", outData, 32'hA);
      checkOutput("bp_in_ready_held", 32'(inReady), 32'd0);
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 4'b0000);
      for (int j = 0; j < 4; j++) begin
         checkOutput("bp_release_valid", 32'(outValid), 32'd1);
         checkOutput("bp_release_data", outData, 32'hA + 32'(j));
         tick();
      end
      checkOutput("bp_release_empty", 32'(outValid), 32'd0);
      checkOutput("bp_stall_kept", 32'(stallCnt), 32'd5);

      // Bubble collapse: beats at cycles 0 and 3 with out_ready low
      applyStimulus(1'b1, 32'h50, 1'b0, 1'b0, 4'b0000);
      tick();
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 4'b0000);
      tick();
      tick();
      applyStimulus(1'b1, 32'h51, 1'b0, 1'b0, 4'b0000);
      tick();
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 4'b0000);
      repeat (4) tick();
      checkOutput("bubble_occupancy", 32'(occupancy), 32'd2);
      checkOutput("bubble_out_data", outData, 32'h50);
      checkOutput("bubble_in_ready", 32'(inReady), 32'd1);
      checkOutput("bubble_stall_cnt", 32'(stallCnt), 32'd9);
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 4'b0000);
      tick();
      checkOutput("bubble_second_adjacent", outData, 32'h51);
      checkOutput("bubble_second_valid", 32'(outValid), 32'd1);
      tick();
      checkOutput("bubble_empty", 32'(outValid), 32'd0);

      // Flush: stages hold s3=H s2=G s1=F s0=E, kill stages 0 and 1
      applyStimulus(1'b1, 32'h48, 1'b0, 1'b0, 4'b0000);
      tick();
      applyStimulus(1'b1, 32'h47, 1'b0, 1'b0, 4'b0000);
      tick();
      applyStimulus(1'b1, 32'h46, 1'b0, 1'b0, 4'b0000);
      tick();
      applyStimulus(1'b1, 32'h45, 1'b0, 1'b0, 4'b0000);
      tick();
      applyStimulus(1'b1, 32'h58, 1'b0, 1'b1, 4'b0011);
      checkOutput("flush_pre_occupancy", 32'(occupancy), 32'd4);
      checkOutput("flush_pre_out_valid", 32'(outValid), 32'd1);
      tick();
      checkOutput("flush_post_occupancy", 32'(occupancy), 32'd2);
      applyStimulus(1'b1, 32'h59, 1'b0, 1'b1, 4'b0001);
      checkOutput("flush_discard_in_ready", 32'(inReady), 32'd1);
      tick();
      checkOutput("flush_discard_occupancy", 32'(occupancy), 32'd2);
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 4'b0000);
      checkOutput("flush_out_first", outData, 32'h48);
      tick();
      checkOutput("flush_out_second", outData, 32'h47);
      checkOutput("flush_out_second_valid", 32'(outValid), 32'd1);
      tick();
      checkOutput("flush_out_done", 32'(outValid), 32'd0);

      // Flush of the oldest stage versus an output transfer in the same cycle
      applyStimulus(1'b1, 32'h4B, 1'b0, 1'b0, 4'b0000);
      tick();
      applyStimulus(1'b1, 32'h4C, 1'b0, 1'b0, 4'b0000);
      tick();
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 4'b0000);
      tick();
      tick();
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 4'b1000);
      checkOutput("fvo_out_valid_ungated", 32'(outValid), 32'd1);
      checkOutput("fvo_out_data", outData, 32'h4B);
      tick();
      checkOutput("fvo_next_data", outData, 32'h4C);
      checkOutput("fvo_occupancy", 32'(occupancy), 32'd1);
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 4'b1000);
      tick();
      checkOutput("fvo_killed_valid", 32'(outValid), 32'd0);
      checkOutput("fvo_killed_occupancy", 32'(occupancy), 32'd0);
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 4'b0000);

      // Skid instance: continuous input, out_ready toggling 1,0,1,0
      nextSend  = 1;
      expNext   = 1;
      delivered = 0;
      for (int cyc = 0; cyc < 80 && delivered < 12; cyc++) begin
         sOutReady = (cyc % 2 == 0);
         sInValid  = (nextSend <= 12);
         sInData   = 32'(nextSend);
         #1;
         if (cyc == 4)
            checkOutput("skid_latency_empty", 32'(sOutValid), 32'd0);
         if (cyc == 5)
            checkOutput("skid_latency_first", 32'(sOutValid), 32'd1);
         if (sOutValid && sOutReady) begin
            checkOutput("skid_order", sOutData, 32'(expNext));
            expNext++;
            delivered++;
         end
         if (sInValid && sInReady)
            nextSend++;
         tick();
      end
      checkOutput("skid_delivered", 32'(delivered), 32'd12);
      checkOutput("skid_drained_occ", 32'(sOcc), 32'd0);

      // Skid instance: fill with out_ready low, saturate the 3-bit stall counter
      sOutReady = 1'b0;
      for (int k = 0; k < 16; k++) begin
         sInValid = 1'b1;
         sInData  = 32'h100 + 32'(k);
         tick();
      end
      sInValid = 1'b0;
      #1;
      checkOutput("skid_full_occ", 32'(sOcc), 32'd6);
      checkOutput("skid_full_in_ready", 32'(sInReady), 32'd0);
      checkOutput("skid_head_data", sOutData, 32'h100);
      checkOutput("skid_stall_saturated", 32'(sStall), 32'd7);
      sOutReady = 1'b1;
      #1;
      checkOutput("skid_no_comb_path", 32'(sInReady), 32'd0);
      sOutReady = 1'b0;

      // Asynchronous reset mid-stream
      applyStimulus(1'b1, 32'h61, 1'b0, 1'b0, 4'b0000);
      tick();
      applyStimulus(1'b1, 32'h62, 1'b0, 1'b0, 4'b0000);
      tick();
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 4'b0000);
      repeat (5) tick();
      checkOutput("pre_reset_out_valid", 32'(outValid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_out_valid", 32'(outValid), 32'd0);
      checkOutput("async_rst_occupancy", 32'(occupancy), 32'd0);
      checkOutput("async_rst_stall_cnt", 32'(stallCnt), 32'd0);
      checkOutput("async_rst_skid_valid", 32'(sOutValid), 32'd0);
      checkOutput("async_rst_skid_occ", 32'(sOcc), 32'd0);
      checkOutput("async_rst_skid_stall", 32'(sStall), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Post-reset single beat through the direct chain
      applyStimulus(1'b1, 32'h55, 1'b1, 1'b0, 4'b0000);
      tick();
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 4'b0000);
      tick();
      tick();
      checkOutput("post_reset_latency", 32'(outValid), 32'd0);
      tick();
      checkOutput("post_reset_valid", 32'(outValid), 32'd1);
      checkOutput("post_reset_data", outData, 32'h55);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
